// File: rtl/ctrl_pkg.sv
// Shared definitions for the main pipeline controller: opcodes, ALUOp codes
// and the control bundle carried down the pipe.
package ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned ALUOP_W  = 3;

    localparam logic [OPCODE_W-1:0] R_TYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] LW     = 7'b0000011;
    localparam logic [OPCODE_W-1:0] SW     = 7'b0100011;
    localparam logic [OPCODE_W-1:0] RTYPEI = 7'b0010011;
    localparam logic [OPCODE_W-1:0] BR     = 7'b1100011;
    localparam logic [OPCODE_W-1:0] JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] LUI    = 7'b0110111;

    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_STORE  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_IMM    = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_LOAD   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_AUIPC  = 3'b101;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI    = 3'b110;

    typedef struct packed {
        logic               alusrc;
        logic               memtoreg;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic [ALUOP_W-1:0] aluop;
        logic               branch;
        logic               auipc;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> control bundle plus illegal flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_bundle_t        ctrl_c,
    output logic                illegal_c
);

    always_comb begin
        ctrl_c    = CTRL_BUBBLE;
        illegal_c = 1'b0;
        case (opcode)
            R_TYPE: begin
                ctrl_c.regwrite = 1'b1;
                ctrl_c.aluop    = ALUOP_RTYPE;
            end
            LW: begin
                ctrl_c.alusrc   = 1'b1;
                ctrl_c.memtoreg = 1'b1;
                ctrl_c.regwrite = 1'b1;
                ctrl_c.memread  = 1'b1;
                ctrl_c.aluop    = ALUOP_LOAD;
            end
            SW: begin
                ctrl_c.alusrc   = 1'b1;
                ctrl_c.memwrite = 1'b1;
                ctrl_c.aluop    = ALUOP_STORE;
            end
            RTYPEI: begin
                ctrl_c.alusrc   = 1'b1;
                ctrl_c.regwrite = 1'b1;
                ctrl_c.aluop    = ALUOP_IMM;
            end
            BR: begin
                ctrl_c.branch = 1'b1;
                ctrl_c.aluop  = ALUOP_BRANCH;
            end
            // JAL writes the link register, so it carries RegWrite.
            JAL: begin
                ctrl_c.regwrite = 1'b1;
                ctrl_c.branch   = 1'b1;
                ctrl_c.aluop    = ALUOP_RTYPE;
            end
            JALR: begin
                ctrl_c.alusrc   = 1'b1;
                ctrl_c.regwrite = 1'b1;
                ctrl_c.branch   = 1'b1;
                ctrl_c.aluop    = ALUOP_IMM;
            end
            AUIPC: begin
                ctrl_c.alusrc   = 1'b1;
                ctrl_c.regwrite = 1'b1;
                ctrl_c.auipc    = 1'b1;
                ctrl_c.aluop    = ALUOP_AUIPC;
            end
            LUI: begin
                ctrl_c.alusrc   = 1'b1;
                ctrl_c.regwrite = 1'b1;
                ctrl_c.aluop    = ALUOP_LUI;
            end
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Main pipeline controller: decodes in ID, carries the control bundle through
// ID/EX -> MEM[*] -> WB, and handles load-use stall, branch flush and memory freeze.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MEM_STAGES = 1,
    parameter int unsigned HAZARD_EN  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                ex_branch_taken,
    input  logic                mem_busy,
    output logic                ex_alusrc,
    output logic                ex_branch,
    output logic                ex_auipc,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_regwrite,
    output logic                wb_memtoreg,
    output logic [REG_AW-1:0]   wb_rd,
    output logic                if_id_en,
    output logic                if_id_flush,
    output logic                ex_illegal
);

    // Stage 0 is ID/EX, stages 1..MEM_STAGES are MEM, the last one is WB.
    localparam int unsigned NSTG   = MEM_STAGES + 2;
    localparam int unsigned WB_IDX = MEM_STAGES + 1;

    ctrl_bundle_t      ctrl_q [NSTG];
    ctrl_bundle_t      ctrl_d [NSTG];
    logic [REG_AW-1:0] rd_q   [NSTG];
    logic [REG_AW-1:0] rd_d   [NSTG];
    logic              illegal_q;
    logic              illegal_d;
    ctrl_bundle_t      dec_ctrl;
    logic              dec_illegal;
    logic              load_use;
    logic              unused_fields;

    ctrl_decode u_decode (
        .opcode    (id_opcode),
        .ctrl_c    (dec_ctrl),
        .illegal_c (dec_illegal)
    );

    // A load is forwardable only from the last MEM stage, so loads in EX and
    // the earlier MEM stages block a dependent instruction in ID.
    always_comb begin
        load_use = 1'b0;
        for (int unsigned i = 0; i < MEM_STAGES; i++) begin
            if (ctrl_q[i].memread && (rd_q[i] != '0) &&
                ((rd_q[i] == id_rs1) || (rd_q[i] == id_rs2))) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use && id_valid && (HAZARD_EN != 0);
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        if (!mem_busy) begin
            for (int unsigned i = 1; i < NSTG; i++) begin
                ctrl_d[i] = ctrl_q[i-1];
                rd_d[i]   = rd_q[i-1];
            end
            illegal_d = id_valid && dec_illegal && !ex_branch_taken && !load_use;
            if (!id_valid || dec_illegal || ex_branch_taken || load_use) begin
                ctrl_d[0] = CTRL_BUBBLE;
                rd_d[0]   = '0;
            end else begin
                ctrl_d[0] = dec_ctrl;
                rd_d[0]   = id_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NSTG; i++) begin
                ctrl_q[i] <= CTRL_BUBBLE;
                rd_q[i]   <= '0;
            end
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    // Not every bundle field is consumed at every stage.
    always_comb begin
        unused_fields = 1'b0;
        for (int unsigned i = 0; i < NSTG; i++) begin
            unused_fields = unused_fields ^ (^ctrl_q[i]);
        end
    end

    assign ex_alusrc   = ctrl_q[0].alusrc;
    assign ex_branch   = ctrl_q[0].branch;
    assign ex_auipc    = ctrl_q[0].auipc;
    assign ex_aluop    = ctrl_q[0].aluop;
    assign ex_rd       = rd_q[0];
    assign mem_read    = ctrl_q[1].memread;
    assign mem_write   = ctrl_q[1].memwrite;
    assign wb_regwrite = ctrl_q[WB_IDX].regwrite;
    assign wb_memtoreg = ctrl_q[WB_IDX].memtoreg;
    assign wb_rd       = rd_q[WB_IDX];

    assign if_id_en    = reset && !mem_busy && (ex_branch_taken || !load_use);
    assign if_id_flush = reset && !mem_busy && ex_branch_taken;
    assign ex_illegal  = reset && !mem_busy && illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed table on a 1-MEM-stage instance plus
// random traffic on 1- and 3-MEM-stage instances checked against a queue model.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [2:0] aluop;
        logic       branch;
        logic       auipc;
        logic [4:0] rd;
        logic       illegal;
    } ent_t;

    typedef struct {
        bit         rst_n;
        bit         v;
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        bit         br, busy;
        logic [4:0] e_rd;
        logic [2:0] e_op;
        bit         e_br, e_en, e_fl, e_wb, e_ill;
    } row_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       br_taken, busy;

    logic       ex_alusrc1, ex_branch1, ex_auipc1, mem_read1, mem_write1;
    logic       wb_regwrite1, wb_memtoreg1, if_id_en1, if_id_flush1, ex_illegal1;
    logic [2:0] ex_aluop1;
    logic [4:0] ex_rd1, wb_rd1;
    logic       ex_alusrc3, ex_branch3, ex_auipc3, mem_read3, mem_write3;
    logic       wb_regwrite3, wb_memtoreg3, if_id_en3, if_id_flush3, ex_illegal3;
    logic [2:0] ex_aluop3;
    logic [4:0] ex_rd3, wb_rd3;

    int   n_vec  = 0;
    int   n_miss = 0;
    ent_t q1[$];
    ent_t q3[$];
    row_t tbl[34];

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(5), .MEM_STAGES(1), .HAZARD_EN(1)) dut1 (
        .clk(clk), .reset(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(br_taken), .mem_busy(busy),
        .ex_alusrc(ex_alusrc1), .ex_branch(ex_branch1), .ex_auipc(ex_auipc1),
        .ex_aluop(ex_aluop1), .ex_rd(ex_rd1), .mem_read(mem_read1), .mem_write(mem_write1),
        .wb_regwrite(wb_regwrite1), .wb_memtoreg(wb_memtoreg1), .wb_rd(wb_rd1),
        .if_id_en(if_id_en1), .if_id_flush(if_id_flush1), .ex_illegal(ex_illegal1)
    );

    pipe_ctrl_unit #(.REG_AW(5), .MEM_STAGES(3), .HAZARD_EN(1)) dut3 (
        .clk(clk), .reset(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(br_taken), .mem_busy(busy),
        .ex_alusrc(ex_alusrc3), .ex_branch(ex_branch3), .ex_auipc(ex_auipc3),
        .ex_aluop(ex_aluop3), .ex_rd(ex_rd3), .mem_read(mem_read3), .mem_write(mem_write3),
        .wb_regwrite(wb_regwrite3), .wb_memtoreg(wb_memtoreg3), .wb_rd(wb_rd3),
        .if_id_en(if_id_en3), .if_id_flush(if_id_flush3), .ex_illegal(ex_illegal3)
    );

    wire [22:0] vec1 = {ex_alusrc1, ex_branch1, ex_auipc1, ex_aluop1, ex_rd1,
                        mem_read1, mem_write1, wb_regwrite1, wb_memtoreg1, wb_rd1,
                        if_id_en1, if_id_flush1, ex_illegal1};
    wire [22:0] vec3 = {ex_alusrc3, ex_branch3, ex_auipc3, ex_aluop3, ex_rd3,
                        mem_read3, mem_write3, wb_regwrite3, wb_memtoreg3, wb_rd3,
                        if_id_en3, if_id_flush3, ex_illegal3};

    // Instruction table: what an issued instruction carries down the pipe.
    function automatic ent_t ref_entry(input logic [6:0] op, input logic [4:0] rd);
        ent_t e;
        e    = '0;
        e.rd = rd;
        case (op)
            OP_R:     begin e.regwrite = 1; e.aluop = 3'd0; end
            OP_LW:    begin e.alusrc = 1; e.memtoreg = 1; e.regwrite = 1; e.memread = 1; e.aluop = 3'd3; end
            OP_SW:    begin e.alusrc = 1; e.memwrite = 1; e.aluop = 3'd1; end
            OP_IMM:   begin e.alusrc = 1; e.regwrite = 1; e.aluop = 3'd2; end
            OP_BR:    begin e.branch = 1; e.aluop = 3'd4; end
            OP_JAL:   begin e.regwrite = 1; e.branch = 1; e.aluop = 3'd0; end
            OP_JALR:  begin e.alusrc = 1; e.regwrite = 1; e.branch = 1; e.aluop = 3'd2; end
            OP_AUIPC: begin e.alusrc = 1; e.regwrite = 1; e.auipc = 1; e.aluop = 3'd5; end
            OP_LUI:   begin e.alusrc = 1; e.regwrite = 1; e.aluop = 3'd6; end
            default:  begin e = '0; e.illegal = 1; end
        endcase
        return e;
    endfunction

    // q[0] is the instruction in EX; q[ms+1] is the one in WB.
    function automatic bit ref_hazard(input ent_t q[$], input int ms);
        if (!id_valid) return 1'b0;
        for (int i = 0; i < ms; i++) begin
            if (q[i].memread && q[i].rd != 5'd0 && (q[i].rd == id_rs1 || q[i].rd == id_rs2))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [22:0] ref_out(input ent_t q[$], input int ms, input bit hz);
        bit live, en, fl, ill;
        live = rst_n && !busy;
        en   = live && (br_taken || !hz);
        fl   = live && br_taken;
        ill  = live && q[0].illegal;
        return {q[0].alusrc, q[0].branch, q[0].auipc, q[0].aluop, q[0].rd,
                q[1].memread, q[1].memwrite, q[ms+1].regwrite, q[ms+1].memtoreg, q[ms+1].rd,
                en, fl, ill};
    endfunction

    task automatic model_reset();
        q1.delete();
        q3.delete();
        for (int i = 0; i < 3; i++) q1.push_back('0);
        for (int i = 0; i < 5; i++) q3.push_back('0);
    endtask

    task automatic model_adv(input bit h1, input bit h3);
        ent_t n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (busy) return;
        n = '0;
        if (id_valid && !br_taken && !h1) n = ref_entry(id_opcode, id_rd);
        void'(q1.pop_back());
        q1.push_front(n);
        n = '0;
        if (id_valid && !br_taken && !h3) n = ref_entry(id_opcode, id_rd);
        void'(q3.pop_back());
        q3.push_front(n);
    endtask

    task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [6:0] op, input int s1,
                         input int s2, input int d, input bit b, input bit bz);
        rst_n     = r;
        id_valid  = v;
        id_opcode = op;
        id_rs1    = 5'(s1);
        id_rs2    = 5'(s2);
        id_rd     = 5'(d);
        br_taken  = b;
        busy      = bz;
    endtask

    // Called just after a negedge with inputs applied: check, clock, update model.
    task automatic step();
        bit h1, h3;
        #1;
        h1 = ref_hazard(q1, 1);
        h3 = ref_hazard(q3, 3);
        chk("model_ms1", vec1, ref_out(q1, 1, h1));
        chk("model_ms3", vec3, ref_out(q3, 3, h3));
        @(posedge clk);
        model_adv(h1, h3);
        @(negedge clk);
    endtask

    function automatic row_t mk(input bit r, input bit v, input logic [6:0] op, input int s1,
                                input int s2, input int d, input bit b, input bit bz,
                                input int erd, input int eop, input bit ebr, input bit een,
                                input bit efl, input bit ewb, input bit eill);
        row_t t;
        t.rst_n = r; t.v = v; t.op = op;
        t.rs1 = 5'(s1); t.rs2 = 5'(s2); t.rd = 5'(d);
        t.br = b; t.busy = bz;
        t.e_rd = 5'(erd); t.e_op = 3'(eop);
        t.e_br = ebr; t.e_en = een; t.e_fl = efl; t.e_wb = ewb; t.e_ill = eill;
        return t;
    endfunction

    initial begin
        int          cnt1, cnt3;
        logic [6:0]  ops[9];
        logic [12:0] act, exp;

        // rst v  op        rs1 rs2 rd br bz | ex_rd aluop br en fl wb ill
        tbl[0]  = mk(0, 0, 7'h00,    0,  0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, OP_LW,   10, 11,  1, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 1, OP_SW,   12, 13,  2, 0, 0,   1, 3, 0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 1, OP_IMM,  14, 15,  3, 0, 0,   2, 1, 0, 1, 0, 0, 0);
        tbl[4]  = mk(1, 1, OP_AUIPC, 0,  0,  4, 0, 0,   3, 2, 0, 1, 0, 1, 0);
        tbl[5]  = mk(1, 1, OP_LUI,   0,  0,  6, 0, 0,   4, 5, 0, 1, 0, 0, 0);
        tbl[6]  = mk(1, 1, OP_JAL,   0,  0,  7, 0, 0,   6, 6, 0, 1, 0, 1, 0);
        tbl[7]  = mk(1, 0, 7'h00,    0,  0,  0, 0, 0,   7, 0, 1, 1, 0, 1, 0);
        tbl[8]  = mk(1, 0, 7'h00,    0,  0,  0, 0, 0,   0, 0, 0, 1, 0, 1, 0);
        tbl[9]  = mk(1, 0, 7'h00,    0,  0,  0, 0, 0,   0, 0, 0, 1, 0, 1, 0);
        tbl[10] = mk(1, 1, OP_LW,    0,  0,  5, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        tbl[11] = mk(1, 1, OP_R,     5,  9,  8, 0, 0,   5, 3, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 1, OP_R,     5,  9,  8, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        tbl[13] = mk(1, 0, 7'h00,    0,  0,  0, 0, 0,   8, 0, 0, 1, 0, 1, 0);
        tbl[14] = mk(1, 1, OP_LW,    0,  0,  0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        tbl[15] = mk(1, 1, OP_R,     0,  0,  9, 0, 0,   0, 3, 0, 1, 0, 1, 0);
        tbl[16] = mk(1, 0, 7'h00,    0,  0,  0, 0, 0,   9, 0, 0, 1, 0, 0, 0);
        tbl[17] = mk(1, 1, OP_LW,    0,  0, 12, 0, 0,   0, 0, 0, 1, 0, 1, 0);
        tbl[18] = mk(1, 1, OP_R,    12,  0, 13, 1, 0,  12, 3, 0, 1, 1, 1, 0);
        tbl[19] = mk(1, 0, 7'h00,    0,  0,  0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        tbl[20] = mk(1, 1, OP_JAL,   0,  0, 14, 0, 0,   0, 0, 0, 1, 0, 1, 0);
        tbl[21] = mk(1, 0, 7'h00,    0,  0,  0, 1, 1,  14, 0, 1, 0, 0, 0, 0);
        tbl[22] = mk(1, 0, 7'h00,    0,  0,  0, 1, 1,  14, 0, 1, 0, 0, 0, 0);
        tbl[23] = mk(1, 0, 7'h00,    0,  0,  0, 1, 1,  14, 0, 1, 0, 0, 0, 0);
        tbl[24] = mk(1, 0, 7'h00,    0,  0,  0, 1, 1,  14, 0, 1, 0, 0, 0, 0);
        tbl[25] = mk(1, 0, 7'h00,    0,  0,  0, 1, 0,  14, 0, 1, 1, 1, 0, 0);
        tbl[26] = mk(1, 0, 7'h00,    0,  0,  0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        tbl[27] = mk(1, 0, 7'h00,    0,  0,  0, 0, 0,   0, 0, 0, 1, 0, 1, 0);
        tbl[28] = mk(1, 1, OP_BAD,   0,  0, 15, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        tbl[29] = mk(1, 0, 7'h00,    0,  0,  0, 0, 0,   0, 0, 0, 1, 0, 0, 1);
        tbl[30] = mk(1, 0, 7'h00,    0,  0,  0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        tbl[31] = mk(1, 1, OP_IMM,   0,  0, 17, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        tbl[32] = mk(0, 1, OP_LUI,   0,  0, 18, 0, 0,  17, 2, 0, 0, 0, 0, 0);
        tbl[33] = mk(1, 0, 7'h00,    0,  0,  0, 0, 0,   0, 0, 0, 1, 0, 0, 0);

        ops = '{OP_R, OP_LW, OP_SW, OP_IMM, OP_BR, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};

        drive(0, 0, 7'h00, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 34; i++) begin
            drive(tbl[i].rst_n, tbl[i].v, tbl[i].op, int'(tbl[i].rs1), int'(tbl[i].rs2),
                  int'(tbl[i].rd), tbl[i].br, tbl[i].busy);
            #1;
            act = {ex_rd1, ex_aluop1, ex_branch1, if_id_en1, if_id_flush1, wb_regwrite1, ex_illegal1};
            exp = {tbl[i].e_rd, tbl[i].e_op, tbl[i].e_br, tbl[i].e_en, tbl[i].e_fl,
                   tbl[i].e_wb, tbl[i].e_ill};
            n_vec++;
            if (act !== exp) begin
                n_miss++;
                $display("FAIL table_row_%0d: got %h, want %h", i, act, exp);
            end
            step();
        end

        // Load followed by a dependent op: stall length tracks the MEM depth.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 7'h00, 0, 0, 0, 0, 0);
            step();
        end
        drive(1, 1, OP_LW, 0, 0, 5, 0, 0);
        step();
        cnt1 = 0;
        cnt3 = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, OP_R, 5, 0, 8, 0, 0);
            #1;
            if (!if_id_en1) cnt1++;
            if (!if_id_en3) cnt3++;
            step();
        end
        n_vec += 2;
        if (cnt1 != 1) begin
            n_miss++;
            $display("FAIL stall_cycles_ms1: got %0d, want 1", cnt1);
        end
        if (cnt3 != 3) begin
            n_miss++;
            $display("FAIL stall_cycles_ms3: got %0d, want 3", cnt3);
        end

        for (int c = 0; c < 3000; c++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            if ($urandom_range(0, 2) == 0) op = OP_LW;
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, op,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), $urandom_range(0, 6) == 0,
                  $urandom_range(0, 4) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
